// File: rtl/fft_bfly_stage.sv
// Radix-2 DIF butterfly stage: buffers the first half of each frame, then emits
// saturated (optionally halved) sum/difference pairs against the second half.
module fft_bfly_stage #(
   parameter int IN_WIDTH  = 9,
   parameter int OUT_WIDTH = 10,
   parameter int NUM       = 16,
   parameter int DATA      = 512,
   localparam int COUNT    = DATA / NUM
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                clr,
   input  logic                                scale,
   input  logic                                valid_in,
   input  logic [NUM-1:0][IN_WIDTH-1:0]        din_re,
   input  logic [NUM-1:0][IN_WIDTH-1:0]        din_im,
   output logic [NUM-1:0][OUT_WIDTH-1:0]       do1_re,
   output logic [NUM-1:0][OUT_WIDTH-1:0]       do1_im,
   output logic [NUM-1:0][OUT_WIDTH-1:0]       do2_re,
   output logic [NUM-1:0][OUT_WIDTH-1:0]       do2_im,
   output logic                                valid_out,
   output logic                                frame_done,
   output logic                                busy,
   output logic                                ovf
);

   localparam int HALF    = COUNT / 2;
   localparam int CW      = $clog2(COUNT);
   localparam int AW      = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int EW      = IN_WIDTH + 2;
   localparam int BW      = 2 * NUM * IN_WIDTH;
   localparam int SAT_MAX = 2 ** (OUT_WIDTH - 1) - 1;
   localparam int SAT_MIN = -(2 ** (OUT_WIDTH - 1));
   localparam logic signed [EW-1:0] RND = EW'(1);

   logic [CW-1:0] beat_cnt;
   logic          frame_scale;
   logic [BW-1:0] buffer [HALF];
   logic [AW-1:0] wr_addr, rd_addr;
   logic [BW-1:0] rd_word;
   logic          accept, second_half, last_beat, clip_any;

   logic [NUM-1:0][OUT_WIDTH-1:0] s_re_d, s_im_d, d_re_d, d_im_d;

   // Extra headroom bit keeps the +1 rounding term from wrapping.
   function automatic logic signed [EW-1:0] combine(input logic signed [IN_WIDTH-1:0] a,
                                                    input logic signed [IN_WIDTH-1:0] b,
                                                    input logic sub,
                                                    input logic scl);
      logic signed [EW-1:0] ae, be, r;
      ae = {{2{a[IN_WIDTH-1]}}, a};
      be = {{2{b[IN_WIDTH-1]}}, b};
      r  = sub ? ae - be : ae + be;
      if (scl) r = (r + RND) >>> 1;
      return r;
   endfunction

   function automatic logic [OUT_WIDTH-1:0] saturate(input logic signed [EW-1:0] v,
                                                     output logic clip);
      logic [OUT_WIDTH-1:0] res;
      clip = 1'b0;
      res  = v[OUT_WIDTH-1:0];
      if (int'(v) > SAT_MAX) begin
         res  = OUT_WIDTH'(SAT_MAX);
         clip = 1'b1;
      end else if (int'(v) < SAT_MIN) begin
         res  = OUT_WIDTH'(SAT_MIN);
         clip = 1'b1;
      end
      return res;
   endfunction

   assign accept      = valid_in && !clr;
   assign second_half = (beat_cnt >= CW'(HALF));
   assign last_beat   = (beat_cnt == CW'(COUNT - 1));
   assign busy        = (beat_cnt != '0);
   assign wr_addr     = AW'(beat_cnt);
   assign rd_addr     = AW'(beat_cnt - CW'(HALF));
   assign rd_word     = buffer[rd_addr];

   always_comb begin : lane_math
      logic signed [IN_WIDTH-1:0] a_re, a_im;
      logic c0, c1, c2, c3;
      clip_any = 1'b0;
      s_re_d   = '0;
      s_im_d   = '0;
      d_re_d   = '0;
      d_im_d   = '0;
      for (int i = 0; i < NUM; i++) begin
         a_re      = rd_word[i*IN_WIDTH +: IN_WIDTH];
         a_im      = rd_word[NUM*IN_WIDTH + i*IN_WIDTH +: IN_WIDTH];
         s_re_d[i] = saturate(combine(a_re, din_re[i], 1'b0, frame_scale), c0);
         s_im_d[i] = saturate(combine(a_im, din_im[i], 1'b0, frame_scale), c1);
         d_re_d[i] = saturate(combine(a_re, din_re[i], 1'b1, frame_scale), c2);
         d_im_d[i] = saturate(combine(a_im, din_im[i], 1'b1, frame_scale), c3);
         clip_any  = clip_any | c0 | c1 | c2 | c3;
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !second_half) buffer[wr_addr] <= {din_im, din_re};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat_cnt    <= '0;
         frame_scale <= 1'b0;
         do1_re      <= '0;
         do1_im      <= '0;
         do2_re      <= '0;
         do2_im      <= '0;
         valid_out   <= 1'b0;
         frame_done  <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         valid_out  <= accept && second_half;
         frame_done <= accept && last_beat;
         if (accept && second_half) begin
            do1_re <= s_re_d;
            do1_im <= s_im_d;
            do2_re <= d_re_d;
            do2_im <= d_im_d;
         end
         // Abort discards this cycle's beat and wins over a simultaneous clip.
         if (clr) begin
            beat_cnt <= '0;
            ovf      <= 1'b0;
         end else if (valid_in) begin
            if (beat_cnt == '0) frame_scale <= scale;
            beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
            if (second_half && clip_any) ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fft_bfly_stage.sv
// Bench for fft_bfly_stage: table-driven frames, random stalled frames and abort/reset
// sequences, checked through an expected-result queue on two output widths (10 and 9).
module tb_fft_bfly_stage;

   localparam int NUM   = 16;
   localparam int DATA  = 512;
   localparam int COUNT = DATA / NUM;
   localparam int HALF  = COUNT / 2;

   logic clk = 1'b0;
   logic rstn, clr, scale, valid_in;
   logic [NUM-1:0][8:0] din_re, din_im;
   logic [NUM-1:0][9:0] a1_re, a1_im, a2_re, a2_im;
   logic [NUM-1:0][8:0] b1_re, b1_im, b2_re, b2_im;
   logic valid0, fd0, busy0, ovf0, valid1, fd1, busy1, ovf1;

   always #5 clk = ~clk;

   fft_bfly_stage #(.IN_WIDTH(9), .OUT_WIDTH(10), .NUM(NUM), .DATA(DATA)) dut (
      .clk(clk), .rstn(rstn), .clr(clr), .scale(scale), .valid_in(valid_in),
      .din_re(din_re), .din_im(din_im),
      .do1_re(a1_re), .do1_im(a1_im), .do2_re(a2_re), .do2_im(a2_im),
      .valid_out(valid0), .frame_done(fd0), .busy(busy0), .ovf(ovf0));

   fft_bfly_stage #(.IN_WIDTH(9), .OUT_WIDTH(9), .NUM(NUM), .DATA(DATA)) dut9 (
      .clk(clk), .rstn(rstn), .clr(clr), .scale(scale), .valid_in(valid_in),
      .din_re(din_re), .din_im(din_im),
      .do1_re(b1_re), .do1_im(b1_im), .do2_re(b2_re), .do2_im(b2_im),
      .valid_out(valid1), .frame_done(fd1), .busy(busy1), .ovf(ovf1));

   typedef struct {
      int are, aim, bre, bim;
      bit scl;
      int s_re, s_im, d_re, d_im;
      int t_re, t_im, u_re, u_im;
      bit ovf9;
   } vec_t;

   typedef struct packed {
      int cyc;
      logic fd;
      logic [NUM-1:0][9:0] s_re, s_im, d_re, d_im;
      logic [NUM-1:0][8:0] t_re, t_im, u_re, u_im;
   } exp_t;

   vec_t tbl [6];
   exp_t q [$];
   exp_t mon_e;
   int   errors = 0, checks = 0, cyc = 0, vo_cnt = 0, fd_cnt = 0;
   int   m_re [HALF][NUM];
   int   m_im [HALF][NUM];
   int   cur_re [NUM];
   int   cur_im [NUM];
   bit   m_scl, m_ovf0, m_ovf9;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic int bf(input int a, input int b, input bit sub, input bit scl,
                             input int ow, output bit clip);
      int r, lim;
      r    = sub ? a - b : a + b;
      if (scl) r = (r + 1) >>> 1;
      lim  = 1 << (ow - 1);
      clip = 1'b0;
      if (r > lim - 1) begin r = lim - 1; clip = 1'b1; end
      else if (r < -lim) begin r = -lim; clip = 1'b1; end
      return r;
   endfunction

   task automatic fill(input int re, input int im);
      for (int i = 0; i < NUM; i++) begin cur_re[i] = re; cur_im[i] = im; end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
   endtask

   // Drives beat k; tv >= 0 takes expectations from the table, otherwise from the model.
   task automatic beat(input int k, input bit scl_in, input int tv);
      exp_t e;
      bit c;
      int ar, ai;
      for (int i = 0; i < NUM; i++) begin
         din_re[i] = 9'(cur_re[i]);
         din_im[i] = 9'(cur_im[i]);
      end
      valid_in = 1'b1;
      scale    = (k == 0) ? scl_in : !scl_in;
      if (k == 0) m_scl = scl_in;
      if (k < HALF) begin
         for (int i = 0; i < NUM; i++) begin m_re[k][i] = cur_re[i]; m_im[k][i] = cur_im[i]; end
      end else begin
         e.cyc = cyc + 1;
         e.fd  = (k == COUNT - 1);
         for (int i = 0; i < NUM; i++) begin
            if (tv >= 0) begin
               e.s_re[i] = 10'(tbl[tv].s_re); e.s_im[i] = 10'(tbl[tv].s_im);
               e.d_re[i] = 10'(tbl[tv].d_re); e.d_im[i] = 10'(tbl[tv].d_im);
               e.t_re[i] = 9'(tbl[tv].t_re);  e.t_im[i] = 9'(tbl[tv].t_im);
               e.u_re[i] = 9'(tbl[tv].u_re);  e.u_im[i] = 9'(tbl[tv].u_im);
            end else begin
               ar = m_re[k-HALF][i];
               ai = m_im[k-HALF][i];
               e.s_re[i] = 10'(bf(ar, cur_re[i], 0, m_scl, 10, c)); m_ovf0 |= c;
               e.s_im[i] = 10'(bf(ai, cur_im[i], 0, m_scl, 10, c)); m_ovf0 |= c;
               e.d_re[i] = 10'(bf(ar, cur_re[i], 1, m_scl, 10, c)); m_ovf0 |= c;
               e.d_im[i] = 10'(bf(ai, cur_im[i], 1, m_scl, 10, c)); m_ovf0 |= c;
               e.t_re[i] = 9'(bf(ar, cur_re[i], 0, m_scl, 9, c));   m_ovf9 |= c;
               e.t_im[i] = 9'(bf(ai, cur_im[i], 0, m_scl, 9, c));   m_ovf9 |= c;
               e.u_re[i] = 9'(bf(ar, cur_re[i], 1, m_scl, 9, c));   m_ovf9 |= c;
               e.u_im[i] = 9'(bf(ai, cur_im[i], 1, m_scl, 9, c));   m_ovf9 |= c;
            end
         end
         q.push_back(e);
      end
      @(posedge clk); #1;
      valid_in = 1'b0;
   endtask

   task automatic frame_tbl(input int tv);
      for (int k = 0; k < COUNT; k++) begin
         if (k < HALF) fill(tbl[tv].are, tbl[tv].aim);
         else          fill(tbl[tv].bre, tbl[tv].bim);
         beat(k, tbl[tv].scl, tv);
         if (k == 0) chk("busy_mid", busy0, 1'b1);
      end
      chk("busy_end", busy0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (valid0 || valid1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_valid: got valid_out=%b/%b want no output", valid0, valid1);
         end else begin
            mon_e = q.pop_front();
            chk("valid_both", {valid0, valid1}, 2'b11);
            chk("valid_cycle", cyc, mon_e.cyc);
            chk("frame_done10", fd0, mon_e.fd);
            chk("frame_done9", fd1, mon_e.fd);
            chk("do1_re10", a1_re, mon_e.s_re);
            chk("do1_im10", a1_im, mon_e.s_im);
            chk("do2_re10", a2_re, mon_e.d_re);
            chk("do2_im10", a2_im, mon_e.d_im);
            chk("do1_re9", b1_re, mon_e.t_re);
            chk("do1_im9", b1_im, mon_e.t_im);
            chk("do2_re9", b2_re, mon_e.u_re);
            chk("do2_im9", b2_im, mon_e.u_im);
         end
         vo_cnt++;
         if (fd0) fd_cnt++;
      end else if (fd0 || fd1) begin
         checks++;
         errors++;
         $display("FAIL spurious_frame_done: got %b/%b want 0", fd0, fd1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

   initial begin
      int vo_base, fd_base;
      tbl[0] = '{10, -3, 4, 5, 0,      14, 2, 6, -8,        14, 2, 6, -8,        0};
      tbl[1] = '{255, -256, 255, 255, 0, 510, -1, 0, -511,  255, -1, 0, -256,    1};
      tbl[2] = '{200, -200, 100, 100, 0, 300, -100, 100, -300, 255, -100, 100, -256, 1};
      tbl[3] = '{7, -7, 4, 4, 1,       6, -1, 2, -5,        6, -1, 2, -5,        0};
      tbl[4] = '{255, -256, 255, -256, 1, 255, -256, 0, 0,  255, -256, 0, 0,     0};
      tbl[5] = '{-256, -256, 255, -256, 0, -1, -512, -511, 0, -1, -256, -256, 0, 1};

      rstn = 1'b1; clr = 1'b0; scale = 1'b0; valid_in = 1'b0; din_re = '0; din_im = '0;
      #1 rstn = 1'b0;
      #3;
      chk("rst_valid", {valid0, valid1}, 2'b00);
      chk("rst_frame_done", {fd0, fd1}, 2'b00);
      chk("rst_busy", {busy0, busy1}, 2'b00);
      chk("rst_ovf", {ovf0, ovf1}, 2'b00);
      chk("rst_do1_re", a1_re, '0);
      chk("rst_do2_im", b2_im, '0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;

      // Table frames; the first two run back-to-back with no idle cycle.
      for (int tv = 0; tv < 6; tv++) begin
         frame_tbl(tv);
         chk("ovf10_frame", ovf0, 1'b0);
         chk("ovf9_frame", ovf1, tbl[tv].ovf9);
         if (tv != 0) begin
            idle(1);
            chk("ovf9_sticky", ovf1, tbl[tv].ovf9);
            pulse_clr();
            chk("ovf9_clr", ovf1, 1'b0);
         end
      end
      idle(1);
      chk("tbl_valid_cnt", vo_cnt, 6 * HALF);
      chk("tbl_frame_done_cnt", fd_cnt, 6);

      // Random lanes, one beat in three, two frames.
      m_ovf0 = 1'b0; m_ovf9 = 1'b0;
      vo_base = vo_cnt; fd_base = fd_cnt;
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < COUNT; k++) begin
            for (int i = 0; i < NUM; i++) begin
               cur_re[i] = int'($urandom_range(0, 511)) - 256;
               cur_im[i] = int'($urandom_range(0, 511)) - 256;
            end
            beat(k, f[0], -1);
            idle(2);
         end
      end
      idle(2);
      chk("rand_valid_cnt", vo_cnt - vo_base, 2 * HALF);
      chk("rand_frame_done_cnt", fd_cnt - fd_base, 2);
      chk("rand_ovf10", ovf0, m_ovf0);
      chk("rand_ovf9", ovf1, m_ovf9);
      pulse_clr();

      // Abort at beat 20 with saturating data, then a fresh frame.
      fill(200, -200);
      for (int k = 0; k < 20; k++) begin
         if (k == HALF) fill(100, 100);
         beat(k, 1'b0, -1);
      end
      chk("ovf9_pre_clr", ovf1, 1'b1);
      valid_in = 1'b1; clr = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0; clr = 1'b0;
      chk("clr_busy", busy0, 1'b0);
      chk("clr_ovf9", ovf1, 1'b0);
      frame_tbl(0);
      chk("clr_fresh_ovf", {ovf0, ovf1}, 2'b00);

      // Same abort point, but via asynchronous reset.
      fill(200, -200);
      for (int k = 0; k < 20; k++) begin
         if (k == HALF) fill(100, 100);
         beat(k, 1'b0, -1);
      end
      #5 rstn = 1'b0;
      #1;
      chk("arst_valid", {valid0, valid1}, 2'b00);
      chk("arst_busy", {busy0, busy1}, 2'b00);
      chk("arst_ovf", {ovf0, ovf1}, 2'b00);
      chk("arst_do1_re", b1_re, '0);
      #1 rstn = 1'b1;
      @(posedge clk); #1;
      frame_tbl(0);
      idle(2);
      chk("arst_fresh_ovf", {ovf0, ovf1}, 2'b00);
      chk("queue_empty", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
